// File: rtl/ahb_lite_pkg.sv
// Shared AHB-lite encodings, the address-phase bundle and a burst-length helper
// used by the two-master front-end arbiter.
package ahb_lite_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [2:0] {
      HBURST_SINGLE = 3'b000,
      HBURST_INCR   = 3'b001,
      HBURST_WRAP4  = 3'b010,
      HBURST_INCR4  = 3'b011,
      HBURST_WRAP8  = 3'b100,
      HBURST_INCR8  = 3'b101,
      HBURST_WRAP16 = 3'b110,
      HBURST_INCR16 = 3'b111
   } hburst_e;

   typedef enum logic [1:0] {
      HRESP_OKAY  = 2'b00,
      HRESP_ERROR = 2'b01
   } hresp_e;

   // One master's address-phase control, as captured and replayed.
   typedef struct packed {
      logic [31:0] haddr;
      logic        hwrite;
      logic [2:0]  hsize;
      logic [2:0]  hburst;
      logic [3:0]  hprot;
      logic [1:0]  htrans;
   } addr_phase_t;

   localparam addr_phase_t ADDR_PHASE_RST = '{
      haddr:  32'h0000_0000,
      hwrite: 1'b0,
      hsize:  3'b000,
      hburst: 3'b000,
      hprot:  4'b0000,
      htrans: 2'b00
   };

   // Remaining beats after the first beat of a fixed-length burst; zero for
   // SINGLE and undefined-length INCR, which never lock the grant.
   function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
      logic [3:0] beats;
      case (hburst)
         HBURST_WRAP4,  HBURST_INCR4:  beats = 4'd3;
         HBURST_WRAP8,  HBURST_INCR8:  beats = 4'd7;
         HBURST_WRAP16, HBURST_INCR16: beats = 4'd15;
         default:                      beats = 4'd0;
      endcase
      return beats;
   endfunction

endpackage

// File: rtl/ahb_lite_hold.sv
// Per-master capture register: stores a transfer the master believes was
// accepted while it did not own the bus, and flags it for replay.
module ahb_lite_hold
   import ahb_lite_pkg::*;
(
   input  logic        pll_core_cpuclk,
   input  logic        pad_cpu_rst_b,
   input  logic        capture,
   input  logic        clear,
   input  addr_phase_t live,
   output addr_phase_t hold,
   output logic        pend
);

   addr_phase_t conv_s;
   addr_phase_t hold_r;
   logic        pend_r;

   // A replay always starts a new burst, so a captured SEQ becomes NONSEQ INCR.
   always_comb begin
      conv_s = live;
      if (live.htrans == HTRANS_SEQ) begin
         conv_s.htrans = HTRANS_NONSEQ;
         conv_s.hburst = HBURST_INCR;
      end else begin
         conv_s.htrans = HTRANS_NONSEQ;
      end
   end

   // Hold register and pending flag; a capture wins over a replay clear.
   always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
      if (!pad_cpu_rst_b) begin
         hold_r <= ADDR_PHASE_RST;
         pend_r <= 1'b0;
      end else if (capture) begin
         hold_r <= conv_s;
         pend_r <= 1'b1;
      end else if (clear) begin
         pend_r <= 1'b0;
      end
   end

   assign hold = hold_r;
   assign pend = pend_r;

endmodule

// File: rtl/ahb_lite_arb2.sv
// Two-master AHB-lite front-end arbiter. The owner passes straight through;
// the other master's address phase is captured and replayed once the grant
// alternates, keeping fixed-length bursts intact when HBURST_LOCK is set.
module ahb_lite_arb2
   import ahb_lite_pkg::*;
#(
   parameter bit HBURST_LOCK = 1'b1
) (
   input  logic        pll_core_cpuclk,
   input  logic        pad_cpu_rst_b,
   input  logic [31:0] m0_haddr,
   input  logic [31:0] m0_hwdata,
   input  logic [2:0]  m0_hburst,
   input  logic [2:0]  m0_hsize,
   input  logic [3:0]  m0_hprot,
   input  logic [1:0]  m0_htrans,
   input  logic        m0_hwrite,
   output logic        m0_hready,
   output logic [31:0] m0_hrdata,
   output logic [1:0]  m0_hresp,
   input  logic [31:0] m1_haddr,
   input  logic [31:0] m1_hwdata,
   input  logic [2:0]  m1_hburst,
   input  logic [2:0]  m1_hsize,
   input  logic [3:0]  m1_hprot,
   input  logic [1:0]  m1_htrans,
   input  logic        m1_hwrite,
   output logic        m1_hready,
   output logic [31:0] m1_hrdata,
   output logic [1:0]  m1_hresp,
   output logic [31:0] bus_haddr,
   output logic [31:0] bus_hwdata,
   output logic [2:0]  bus_hburst,
   output logic [2:0]  bus_hsize,
   output logic [3:0]  bus_hprot,
   output logic [1:0]  bus_htrans,
   output logic        bus_hwrite,
   input  logic [31:0] bus_hrdata,
   input  logic        bus_hready,
   input  logic [1:0]  bus_hresp
);

   addr_phase_t live0_s, live1_s, hold0_s, hold1_s, bus_s;
   logic        pend0_s, pend1_s, pend0_nx_s, pend1_nx_s;
   logic        capture0_s, capture1_s, clear0_s, clear1_s;
   logic        hready0_s, hready1_s, gnt_nx_s;
   logic [3:0]  beats_nx_s;
   logic        gnt_r, dp_valid_r, dp_src_r;
   logic [3:0]  beats_r;

   // Bundle the live master inputs into address-phase records.
   always_comb begin
      live0_s = '{haddr: m0_haddr, hwrite: m0_hwrite, hsize: m0_hsize,
                  hburst: m0_hburst, hprot: m0_hprot, htrans: m0_htrans};
      live1_s = '{haddr: m1_haddr, hwrite: m1_hwrite, hsize: m1_hsize,
                  hburst: m1_hburst, hprot: m1_hprot, htrans: m1_htrans};
   end

   // Per-master ready, capture (non-owner, or owner already replaying) and replay clear.
   always_comb begin
      hready0_s  = (dp_valid_r && !dp_src_r) ? bus_hready : !pend0_s;
      hready1_s  = (dp_valid_r &&  dp_src_r) ? bus_hready : !pend1_s;
      capture0_s = live0_s.htrans[1] && hready0_s && (gnt_r  || pend0_s);
      capture1_s = live1_s.htrans[1] && hready1_s && (!gnt_r || pend1_s);
      clear0_s   = bus_hready && !gnt_r && pend0_s;
      clear1_s   = bus_hready &&  gnt_r && pend1_s;
      pend0_nx_s = capture0_s || (pend0_s && !clear0_s);
      pend1_nx_s = capture1_s || (pend1_s && !clear1_s);
   end

   ahb_lite_hold u_hold0 (
      .pll_core_cpuclk (pll_core_cpuclk),
      .pad_cpu_rst_b   (pad_cpu_rst_b),
      .capture         (capture0_s),
      .clear           (clear0_s),
      .live            (live0_s),
      .hold            (hold0_s),
      .pend            (pend0_s)
   );

   ahb_lite_hold u_hold1 (
      .pll_core_cpuclk (pll_core_cpuclk),
      .pad_cpu_rst_b   (pad_cpu_rst_b),
      .capture         (capture1_s),
      .clear           (clear1_s),
      .live            (live1_s),
      .hold            (hold1_s),
      .pend            (pend1_s)
   );

   // Address mux: the owner's pending replay takes priority over its live inputs.
   always_comb begin
      if (gnt_r && pend1_s) begin
         bus_s        = hold1_s;
         bus_s.htrans = HTRANS_NONSEQ;
      end else if (!gnt_r && pend0_s) begin
         bus_s        = hold0_s;
         bus_s.htrans = HTRANS_NONSEQ;
      end else if (gnt_r) begin
         bus_s = live1_s;
      end else begin
         bus_s = live0_s;
      end
   end

   // Burst lock counter and grant decision, both evaluated at accept edges only.
   always_comb begin
      beats_nx_s = beats_r;
      gnt_nx_s   = gnt_r;
      if (!HBURST_LOCK) begin
         beats_nx_s = 4'd0;
      end else if (!bus_hready) begin
         beats_nx_s = beats_r;
      end else begin
         case (htrans_e'(bus_s.htrans))
            HTRANS_NONSEQ: beats_nx_s = burst_beats(bus_s.hburst);
            HTRANS_SEQ:    beats_nx_s = (beats_r != 4'd0) ? beats_r - 4'd1 : 4'd0;
            HTRANS_BUSY:   beats_nx_s = beats_r;
            default:       beats_nx_s = 4'd0;
         endcase
      end
      if (bus_hready && (beats_nx_s == 4'd0) && (gnt_r ? pend0_nx_s : pend1_nx_s)) begin
         gnt_nx_s = !gnt_r;
      end else begin
         gnt_nx_s = gnt_r;
      end
   end

   // Grant, burst counter and data-phase tracker.
   always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
      if (!pad_cpu_rst_b) begin
         gnt_r      <= 1'b0;
         beats_r    <= 4'd0;
         dp_valid_r <= 1'b0;
         dp_src_r   <= 1'b0;
      end else begin
         gnt_r   <= gnt_nx_s;
         beats_r <= beats_nx_s;
         if (bus_hready) begin
            dp_valid_r <= bus_s.htrans[1];
            dp_src_r   <= gnt_r;
         end
      end
   end

   assign bus_haddr  = bus_s.haddr;
   assign bus_hwrite = bus_s.hwrite;
   assign bus_hsize  = bus_s.hsize;
   assign bus_hburst = bus_s.hburst;
   assign bus_hprot  = bus_s.hprot;
   assign bus_htrans = bus_s.htrans;
   assign bus_hwdata = dp_src_r ? m1_hwdata : m0_hwdata;
   assign m0_hready  = hready0_s;
   assign m1_hready  = hready1_s;
   assign m0_hrdata  = bus_hrdata;
   assign m1_hrdata  = bus_hrdata;
   assign m0_hresp   = bus_hresp;
   assign m1_hresp   = bus_hresp;

endmodule

// File: tb/tb_ahb_lite_arb2.sv
// Directed self-checking bench for ahb_lite_arb2. Inputs change just after
// the falling edge; outputs are sampled 1 ns later, away from the rising edge.
module tb_ahb_lite_arb2;

   logic        clk = 1'b0;
   logic        rst_b;
   logic [31:0] m0_haddr, m0_hwdata, m1_haddr, m1_hwdata;
   logic [2:0]  m0_hburst, m0_hsize, m1_hburst, m1_hsize;
   logic [3:0]  m0_hprot, m1_hprot;
   logic [1:0]  m0_htrans, m1_htrans;
   logic        m0_hwrite, m1_hwrite;
   logic        m0_hready, m1_hready;
   logic [31:0] m0_hrdata, m1_hrdata;
   logic [1:0]  m0_hresp, m1_hresp;
   logic [31:0] bus_haddr, bus_hwdata, bus_hrdata;
   logic [2:0]  bus_hburst, bus_hsize;
   logic [3:0]  bus_hprot;
   logic [1:0]  bus_htrans, bus_hresp;
   logic        bus_hwrite, bus_hready;

   int checks = 0;
   int errors = 0;

   localparam logic [1:0] IDLE = 2'b00, NSEQ = 2'b10, SEQ = 2'b11;
   localparam logic [2:0] SINGLE = 3'b000, INCR4 = 3'b011;

   ahb_lite_arb2 dut (
      .pll_core_cpuclk (clk),        .pad_cpu_rst_b (rst_b),
      .m0_haddr  (m0_haddr),  .m0_hwdata (m0_hwdata), .m0_hburst (m0_hburst),
      .m0_hsize  (m0_hsize),  .m0_hprot  (m0_hprot),  .m0_htrans (m0_htrans),
      .m0_hwrite (m0_hwrite), .m0_hready (m0_hready), .m0_hrdata (m0_hrdata),
      .m0_hresp  (m0_hresp),
      .m1_haddr  (m1_haddr),  .m1_hwdata (m1_hwdata), .m1_hburst (m1_hburst),
      .m1_hsize  (m1_hsize),  .m1_hprot  (m1_hprot),  .m1_htrans (m1_htrans),
      .m1_hwrite (m1_hwrite), .m1_hready (m1_hready), .m1_hrdata (m1_hrdata),
      .m1_hresp  (m1_hresp),
      .bus_haddr (bus_haddr), .bus_hwdata (bus_hwdata), .bus_hburst (bus_hburst),
      .bus_hsize (bus_hsize), .bus_hprot (bus_hprot),   .bus_htrans (bus_htrans),
      .bus_hwrite (bus_hwrite), .bus_hrdata (bus_hrdata), .bus_hready (bus_hready),
      .bus_hresp (bus_hresp)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic drv0(input logic [1:0] tr, input logic [31:0] a,
                       input logic [2:0] b, input logic w);
      m0_htrans = tr; m0_haddr = a; m0_hburst = b; m0_hwrite = w;
   endtask

   task automatic drv1(input logic [1:0] tr, input logic [31:0] a,
                       input logic [2:0] b, input logic w);
      m1_htrans = tr; m1_haddr = a; m1_hburst = b; m1_hwrite = w;
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      rst_b = 1'b0;
      m0_hsize = 3'b010; m1_hsize = 3'b010; m0_hprot = 4'b0011; m1_hprot = 4'b0011;
      m0_hwdata = 32'h0; m1_hwdata = 32'h0;
      drv0(IDLE, 32'h1234_5678, SINGLE, 1'b0);
      drv1(IDLE, 32'h0, SINGLE, 1'b0);
      bus_hready = 1'b1; bus_hresp = 2'b00; bus_hrdata = 32'h0;
      #1;
      // Reset state: both ready, bus follows m0 live inputs.
      check("rst_m0_hready", {31'd0, m0_hready}, 32'd1);
      check("rst_m1_hready", {31'd0, m1_hready}, 32'd1);
      check("rst_bus_haddr", bus_haddr, 32'h1234_5678);

      // m0 single read, no contention.
      step(); rst_b = 1'b1;
      drv0(NSEQ, 32'h6000_0000, SINGLE, 1'b0); #1;
      check("single_haddr", bus_haddr, 32'h6000_0000);
      check("single_htrans", {30'd0, bus_htrans}, {30'd0, NSEQ});
      check("single_m1_hready", {31'd0, m1_hready}, 32'd1);
      step(); drv0(IDLE, 32'h6000_0000, SINGLE, 1'b0); bus_hrdata = 32'h1111_2222; #1;
      check("single_m0_hready", {31'd0, m0_hready}, 32'd1);
      check("single_m0_hrdata", m0_hrdata, 32'h1111_2222);
      check("single_m1_hready2", {31'd0, m1_hready}, 32'd1);

      // Simultaneous NONSEQ: m0 forwarded, m1 captured and replayed next cycle.
      step(); drv0(NSEQ, 32'h2000_0000, SINGLE, 1'b0); drv1(NSEQ, 32'h7000_0000, SINGLE, 1'b0); #1;
      check("simul_haddr0", bus_haddr, 32'h2000_0000);
      check("simul_m1_hready0", {31'd0, m1_hready}, 32'd1);
      step(); drv0(IDLE, 32'h0, SINGLE, 1'b0); drv1(IDLE, 32'h0, SINGLE, 1'b0); #1;
      check("simul_haddr1", bus_haddr, 32'h7000_0000);
      check("simul_htrans1", {30'd0, bus_htrans}, {30'd0, NSEQ});
      check("simul_m1_hready1", {31'd0, m1_hready}, 32'd0);
      check("simul_m0_hready1", {31'd0, m0_hready}, 32'd1);
      step(); #1;
      check("simul_m1_hready2", {31'd0, m1_hready}, 32'd1);
      check("simul_htrans2", {30'd0, bus_htrans}, {30'd0, IDLE});

      // Grant is now m1: m1 forwarded, m0 captured; then 3 wait states with ERROR.
      step(); drv0(NSEQ, 32'h2000_0100, SINGLE, 1'b0); drv1(NSEQ, 32'h7000_0100, SINGLE, 1'b0); #1;
      check("ws_haddr0", bus_haddr, 32'h7000_0100);
      check("ws_m0_hready0", {31'd0, m0_hready}, 32'd1);
      step(); drv0(IDLE, 32'h0, SINGLE, 1'b0); drv1(IDLE, 32'h0, SINGLE, 1'b0);
      bus_hready = 1'b0; bus_hresp = 2'b01;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("ws_m1_hready", {31'd0, m1_hready}, 32'd0);
         check("ws_m0_hready", {31'd0, m0_hready}, 32'd0);
         check("ws_replay_haddr", bus_haddr, 32'h2000_0100);
         check("ws_m0_hresp", {30'd0, m0_hresp}, 32'd1);
         step();
      end
      bus_hready = 1'b1; #1;
      check("ws_m1_hready_end", {31'd0, m1_hready}, 32'd1);
      check("ws_replay_after_err", bus_haddr, 32'h2000_0100);
      step(); bus_hresp = 2'b00; #1;
      check("ws_m0_dphase", {31'd0, m0_hready}, 32'd1);
      check("ws_replay_done", {30'd0, bus_htrans}, {30'd0, IDLE});

      // m0 INCR4 at 0x10; m1 requests at beat 1; burst completes before replay.
      step(); drv0(NSEQ, 32'h0000_0010, INCR4, 1'b0); #1;
      check("b4_beat0", bus_haddr, 32'h0000_0010);
      step(); drv0(SEQ, 32'h0000_0014, INCR4, 1'b0); drv1(NSEQ, 32'h7000_0200, SINGLE, 1'b0); #1;
      check("b4_beat1", bus_haddr, 32'h0000_0014);
      check("b4_m1_hready_cap", {31'd0, m1_hready}, 32'd1);
      step(); drv0(SEQ, 32'h0000_0018, INCR4, 1'b0); drv1(IDLE, 32'h0, SINGLE, 1'b0); #1;
      check("b4_beat2", bus_haddr, 32'h0000_0018);
      check("b4_m1_hready_pend", {31'd0, m1_hready}, 32'd0);
      step(); drv0(SEQ, 32'h0000_001C, INCR4, 1'b0); #1;
      check("b4_beat3", bus_haddr, 32'h0000_001C);
      step(); drv0(IDLE, 32'h0, SINGLE, 1'b0); #1;
      check("b4_replay_haddr", bus_haddr, 32'h7000_0200);
      check("b4_replay_htrans", {30'd0, bus_htrans}, {30'd0, NSEQ});
      step(); #1;
      check("b4_m1_dphase", {31'd0, m1_hready}, 32'd1);

      // Grant m1: m0 write captured (gnt->0), then m1 write captured behind m0 replay.
      step(); drv0(NSEQ, 32'h2000_0300, SINGLE, 1'b1); #1;
      check("wr_m0_cap_hready", {31'd0, m0_hready}, 32'd1);
      step(); drv0(IDLE, 32'h0, SINGLE, 1'b0); m0_hwdata = 32'h0BAD_F00D;
      drv1(NSEQ, 32'h7000_0000, SINGLE, 1'b1); #1;
      check("wr_m0_replay", bus_haddr, 32'h2000_0300);
      check("wr_m1_cap_hready", {31'd0, m1_hready}, 32'd1);
      step(); drv1(IDLE, 32'h0, SINGLE, 1'b0); m1_hwdata = 32'hA5A5_A5A5; #1;
      check("wr_m1_replay_haddr", bus_haddr, 32'h7000_0000);
      check("wr_m1_replay_hwrite", {31'd0, bus_hwrite}, 32'd1);
      check("wr_m0_data", bus_hwdata, 32'h0BAD_F00D);
      check("wr_m1_hready_pend", {31'd0, m1_hready}, 32'd0);
      step(); #1;
      check("wr_m1_data", bus_hwdata, 32'hA5A5_A5A5);
      check("wr_m1_hready_dp", {31'd0, m1_hready}, 32'd1);

      // Reset during a pending replay clears everything at once.
      step(); m1_hwdata = 32'h0; drv0(NSEQ, 32'h2000_0400, SINGLE, 1'b0); #1;
      step(); drv0(IDLE, 32'h3333_0000, SINGLE, 1'b0); bus_hready = 1'b0; #1;
      check("rp_pending_haddr", bus_haddr, 32'h2000_0400);
      check("rp_m0_hready_pend", {31'd0, m0_hready}, 32'd0);
      rst_b = 1'b0; #1;
      check("rp_m0_hready", {31'd0, m0_hready}, 32'd1);
      check("rp_m1_hready", {31'd0, m1_hready}, 32'd1);
      check("rp_bus_haddr", bus_haddr, 32'h3333_0000);
      check("rp_bus_htrans", {30'd0, bus_htrans}, {30'd0, IDLE});
      step(); rst_b = 1'b1; bus_hready = 1'b1; #1;
      step(); #1;
      check("post_rst_haddr", bus_haddr, 32'h3333_0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
